// File: rtl/ef_gpio8_apb_arbiter_if.sv
// APB master-side bus bundle between the two-requester arbiter and one APB slave.
//   master modport: drives PADDR/PWRITE/PSEL/PENABLE/PWDATA, samples PRDATA/PREADY
//   slave  modport: the mirror image, for the slave (or a testbench model)
interface ef_gpio8_apb_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  modport master (
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/ef_gpio8_apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// One transfer at a time: IDLE -> SETUP -> ACCESS -> IDLE. An ACCESS phase
// that sees PREADY low for too long is aborted and reported with err.
// Ports:
//   PCLK, PRESETn          clock, async active-low reset
//   req/we/addr/wdata 0,1  requester transfer requests (held until ack)
//   ack0/ack1, err0/err1   one-cycle completion / timeout pulses
//   rdata                  data of the last successfully completed read
//   busy                   high while a transfer is in flight
//   apb                    APB master signals (PADDR..PREADY)
module ef_gpio8_apb_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           req0,
  input  logic                           req1,
  input  logic                           we0,
  input  logic                           we1,
  input  logic [31:0]                    addr0,
  input  logic [31:0]                    addr1,
  input  logic [31:0]                    wdata0,
  input  logic [31:0]                    wdata1,
  output logic                           ack0,
  output logic                           ack1,
  output logic                           err0,
  output logic                           err1,
  output logic [31:0]                    rdata,
  output logic                           busy,
  ef_gpio8_apb_arbiter_if.master         apb
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  // Index of the most recent grant; also identifies the owner while busy.
  logic          last_grant;

  // A requester that was just acked is not eligible, so it cannot be
  // re-granted on its own ack cycle.
  logic elig0_c;
  logic elig1_c;
  logic pick1_c;

  assign elig0_c = req0 & ~ack0;
  assign elig1_c = req1 & ~ack1;
  // Requester 1 wins when it is alone, or on a tie when 0 was granted last.
  assign pick1_c = elig1_c & (~elig0_c | ~last_grant);

  // Transfer sequencing, grant latching and completion/timeout reporting.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      last_grant  <= 1'b1;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      rdata       <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;

      unique case (state)
        IDLE: begin
          if (elig0_c || elig1_c) begin
            last_grant  <= pick1_c;
            apb.PADDR   <= pick1_c ? addr1  : addr0;
            apb.PWRITE  <= pick1_c ? we1    : we0;
            apb.PWDATA  <= pick1_c ? wdata1 : wdata0;
            apb.PSEL    <= 1'b1;
            apb.PENABLE <= 1'b0;
            wait_cnt    <= '0;
            busy        <= 1'b1;
            state       <= SETUP;
          end
        end

        SETUP: begin
          apb.PENABLE <= 1'b1;
          state       <= ACCESS;
        end

        ACCESS: begin
          // PREADY wins over a timeout landing on the same cycle.
          if (apb.PREADY) begin
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            ack0        <= ~last_grant;
            ack1        <= last_grant;
            if (!apb.PWRITE) rdata <= apb.PRDATA;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (wait_cnt == TIMEOUT_C) begin
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            ack0        <= ~last_grant;
            ack1        <= last_grant;
            err0        <= ~last_grant;
            err1        <= last_grant;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        default: begin
          apb.PSEL    <= 1'b0;
          apb.PENABLE <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ef_gpio8_apb_arbiter.md
EF_GPIO8_APB_ARBITER -- requirements
Module: ef_gpio8_apb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, which sets the maximum ACCESS-phase cycles with PREADY=0 before the transfer is aborted (legal range 1..255).
REQ-002 SHALL have these ports, one per entry (name  direction  width  meaning):
- PCLK  in  1  single clock; all state updates on rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- req0/req1  in  1  requester n transfer request, held high until its ack.
- we0/we1  in  1  requester n direction, 1=write, 0=read.
- addr0/addr1  in  32  requester n APB address.
- wdata0/wdata1  in  32  requester n write data.
- ack0/ack1  out  1  one-cycle completion pulse to requester n.
- err0/err1  out  1  one-cycle timeout-error pulse, coincident with ack.
- rdata  out  32  read data of the last completed read.
- busy  out  1  high whenever FSM is not IDLE.
- PADDR  out  32, PWRITE  out  1, PSEL  out  1, PENABLE  out  1, PWDATA  out  32  APB master outputs toward one slave (EF_GPIO8_apb).
- PRDATA  in  32, PREADY  in  1  APB slave responses.

Function
REQ-003 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-004 SHALL treat requester n as eligible in IDLE only if reqn=1 and ackn=0 in that cycle.
REQ-005 SHALL grant, when one requester is eligible, that requester; when both are eligible, the requester not granted last (round-robin, last_grant register).
REQ-006 SHALL, on grant in IDLE, latch granted addr/we/wdata into PADDR/PWRITE/PWDATA, set PSEL=1, PENABLE=0, enter SETUP.
REQ-007 SHALL move SETUP->ACCESS unconditionally after one cycle, setting PENABLE=1; PADDR/PWRITE/PWDATA/PSEL stable through ACCESS.
REQ-008 SHALL, in ACCESS with PREADY=1, clear PSEL/PENABLE, pulse granted ack for exactly one cycle, load rdata from PRDATA if PWRITE=0, return to IDLE.
REQ-009 SHALL count ACCESS cycles with PREADY=0 in an 8-bit wait counter cleared on entry to SETUP.
REQ-010 SHALL, when the wait counter equals TIMEOUT and PREADY=0, abort: clear PSEL/PENABLE, pulse ack and err of granted requester, leave rdata unchanged, return to IDLE.
REQ-011 SHALL give PREADY=1 priority over timeout in the same cycle (normal completion, err=0).
REQ-012 SHALL leave PADDR/PWRITE/PWDATA at last values in IDLE; rdata holds until next successful read.
REQ-013 SHALL yield minimum transfer latency of 3 cycles grant-to-ack (SETUP, ACCESS with PREADY=1, ack in IDLE) and no back-to-back grant to the same requester in its ack cycle.
REQ-014 SHALL never assert ack0 and ack1 simultaneously; at most one transfer outstanding.
REQ-015 SHALL ignore requester signal changes after grant until completion (values latched).
REQ-016 SHALL drive busy=1 in SETUP and ACCESS, 0 in IDLE.

Reset
REQ-017 SHALL, while PRESETn=0, asynchronously force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, ack0/ack1=0, err0/err1=0, busy=0, wait counter=0, last_grant=1 (requester 0 wins first tie).
REQ-018 SHALL, on reset asserted mid-transfer, abandon the transfer with no ack/err pulse; first grant occurs on the first rising edge after PRESETn deasserts.

Verification
REQ-019 Single write: req0, we0=1, addr0=0x4, wdata0=0xFF, slave PREADY=1 -> PSEL rises next edge, PENABLE one cycle later, ack0 one pulse 3 cycles after grant, err0=0, rdata unchanged.
REQ-020 Read with 2 wait states: req1, we1=0, PRDATA=0xAB, PREADY low 2 ACCESS cycles -> ack1 after 5 cycles, rdata=0x000000AB, busy high 4 cycles.
REQ-021 Contention: req0 and req1 asserted same cycle after reset, held until ack -> requester 0 served first, then requester 1; sustained both -> strict alternation 0,1,0,1.
REQ-022 Timeout: TIMEOUT=4, PREADY held 0 -> PSEL/PENABLE drop after 4 ACCESS wait cycles, ack0 and err0 pulse together, rdata unchanged.
REQ-023 Boundary PREADY=1 on cycle where counter equals TIMEOUT -> normal completion, err=0, rdata loaded.
REQ-024 Reset during ACCESS -> PSEL/PENABLE low immediately (before next edge), no ack; reissued request after reset completes normally.
